// File: rtl/ping_pkg.sv
// Shared definitions for the ultrasonic ping driver: FSM encodings and the
// fixed-point constants that turn an echo duration (in 1 us ticks) into mm.
package ping_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_TRIGGER   = 3'd1,
    ST_HOLDOFF   = 3'd2,
    ST_WAIT_ECHO = 3'd3,
    ST_MEASURE   = 3'd4,
    ST_COOLDOWN  = 3'd5
  } state_e;

  // mm = (us * 11239 + 32768) >> 16, i.e. us * 0.1715 rounded to nearest
  localparam int unsigned DIST_SCALE = 11239;
  localparam int unsigned DIST_ROUND = 32768;
  localparam int unsigned DIST_SHIFT = 16;

endpackage

// File: rtl/ping_if.sv
// Observation bundle for the driver's result side: measured distance,
// line-release flag and FSM state.
interface ping_if
  import ping_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic [WIDTH-1:0]   distance;
  logic               listening;
  logic [STATE_W-1:0] state;

  modport master (output distance, output listening, output state);
  modport slave  (input  distance, input  listening, input  state);

endinterface

// File: rtl/ping_sync.sv
// Two-flop synchronizer bringing the asynchronous echo level into clk.
module ping_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ping_driver.sv
// Single-wire ultrasonic ranger driver: pulses the sensor line, releases it,
// times the returning echo and converts the duration to millimetres.
module ping_driver
  import ping_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int TRIG_CYCLES     = 5,
  parameter int HOLDOFF_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES  = 20000,
  parameter int COOLDOWN_CYCLES = 200
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire                 sensor,
  output logic [WIDTH-1:0]    distance,
  output logic                listening,
  output logic [STATE_W-1:0]  state
);

  localparam int MAX_AB = (TIMEOUT_CYCLES > COOLDOWN_CYCLES) ? TIMEOUT_CYCLES : COOLDOWN_CYCLES;
  localparam int MAX_CD = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
  localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int PW     = $clog2(TIMEOUT_CYCLES + 1) + 15;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dist_q, dist_d;
  logic             echo_s;

  // Rounded scaling with saturation to all ones when the result overflows.
  function automatic logic [WIDTH-1:0] to_mm(input logic [CW-1:0] c);
    logic [PW-1:0] prod;
    logic [PW-1:0] mm;
    prod = PW'(c) * PW'(DIST_SCALE) + PW'(DIST_ROUND);
    mm   = prod >> DIST_SHIFT;
    if ((mm >> WIDTH) != '0) to_mm = '1;
    else                     to_mm = WIDTH'(mm);
  endfunction

  ping_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sensor),
    .q_o   (echo_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_TRIGGER;
        cnt_d   = '0;
      end
      ST_TRIGGER: begin
        if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
          state_d = ST_WAIT_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_ECHO: begin
        // The cycle that first sees echo counts as the first echo cycle.
        if (echo_s) begin
          state_d = ST_MEASURE;
          cnt_d   = CW'(1);
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
          dist_d  = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!echo_s) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
          dist_d  = to_mm(cnt_q);
        end else if (cnt_q >= CW'(TIMEOUT_CYCLES)) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
          dist_d  = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == CW'(COOLDOWN_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign listening = (state_q == ST_WAIT_ECHO) || (state_q == ST_MEASURE);
  assign sensor    = listening ? 1'bz : (state_q == ST_TRIGGER);
  assign distance  = dist_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ping_driver.sv
// Scoreboard bench for ping_driver: stimulus queues expected distances, a
// monitor checks them whenever the FSM enters COOLDOWN.
`timescale 1ns/1ps
module tb_ping_driver;
  import ping_pkg::*;

  localparam int WIDTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic echo  = 1'b0;
  wire  sensor;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_v;
  logic [2:0]       prev_st = 3'd0;

  ping_if #(.WIDTH(WIDTH)) bus ();

  always #500 clk = ~clk;

  assign sensor = bus.listening ? echo : 1'bz;

  ping_driver #(
    .WIDTH(WIDTH), .TRIG_CYCLES(5), .HOLDOFF_CYCLES(2),
    .TIMEOUT_CYCLES(20000), .COOLDOWN_CYCLES(200)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sensor    (sensor),
    .distance  (bus.distance),
    .listening (bus.listening),
    .state     (bus.state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (bus.state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.state !== s) begin
      checks++;
      errors++;
      $display("FAIL %s timed out actual=%0d required=%0d", name, bus.state, s);
    end
  endtask

  // Drive an echo of n cycles starting at the first listening cycle.
  task automatic echo_pulse(input int n, input logic [WIDTH-1:0] exp);
    int k = 0;
    wait_state(3'd3, 2000, "wait_listen");
    exp_q.push_back(exp);
    echo = 1'b1;
    repeat (n) begin
      @(negedge clk);
      k++;
      if (k == 5) begin
        chk("measure_state", 32'(bus.state), 32'd4);
        chk("measure_listening", 32'(bus.listening), 32'd1);
      end
    end
    echo = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.state == 3'd5 && prev_st != 3'd5) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", bus.distance);
      end else begin
        exp_v = exp_q.pop_front();
        chk("distance", 32'(bus.distance), 32'(exp_v));
        chk("result_listening", 32'(bus.listening), 32'd0);
      end
    end
    prev_st = bus.state;
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_listening", 32'(bus.listening), 32'd0);
    chk("rst_distance", 32'(bus.distance), 32'd0);
    chk("rst_sensor", 32'(sensor), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("trig_state", 32'(bus.state), 32'd1);
      chk("trig_sensor", 32'(sensor), 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("holdoff_state", 32'(bus.state), 32'd2);
      chk("holdoff_sensor", 32'(sensor), 32'd0);
    end
    @(negedge clk);
    chk("wait_state", 32'(bus.state), 32'd3);
    chk("wait_listening", 32'(bus.listening), 32'd1);

    // 10 us echo -> 2 mm, then a full cooldown before the next trigger
    echo_pulse(10, 16'd2);
    wait_state(3'd5, 100, "wait_cooldown");
    n = 0;
    while (bus.state == 3'd5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("cooldown_len", 32'(n), 32'd200);
    chk("cooldown_exit", 32'(bus.state), 32'd0);
    @(negedge clk);
    chk("retrigger_state", 32'(bus.state), 32'd1);
    chk("distance_hold", 32'(bus.distance), 32'd2);

    echo_pulse(583, 16'd100);
    echo_pulse(5831, 16'd1000);

    // Echo already asserted when the line is released
    wait_state(3'd2, 2000, "wait_holdoff");
    echo = 1'b1;
    wait_state(3'd3, 10, "wait_listen_hi");
    exp_q.push_back(16'd2);
    repeat (10) @(negedge clk);
    echo = 1'b0;

    // No echo at all -> timeout after 20000 cycles
    wait_state(3'd3, 2000, "wait_listen_to");
    exp_q.push_back(16'hFFFF);
    n = 0;
    while (bus.state == 3'd3 && n < 25000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_len", 32'(n), 32'd20000);
    chk("timeout_state", 32'(bus.state), 32'd5);

    // Reset in the middle of a measurement aborts it without a result
    wait_state(3'd3, 2000, "wait_listen_rst");
    echo = 1'b1;
    wait_state(3'd4, 20, "wait_measure_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    echo = 1'b0;
    chk("abort_state", 32'(bus.state), 32'd0);
    chk("abort_listening", 32'(bus.listening), 32'd0);
    chk("abort_distance", 32'(bus.distance), 32'd0);
    chk("abort_sensor", 32'(sensor), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_state", 32'(bus.state), 32'd1);
    chk("post_rst_distance", 32'(bus.distance), 32'd0);
    chk("pending_results", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ping_driver.md
PING_DRIVER -- requirements
Module: ping_driver

Interface
REQ-001 Parameter WIDTH, default 16, width of distance output in mm.
REQ-002 Parameter TRIG_CYCLES, default 5, trigger pulse length in clk cycles (1 us each at 1 MHz).
REQ-003 Parameter HOLDOFF_CYCLES, default 2, low-drive cycles between trigger and releasing the line.
REQ-004 Parameter TIMEOUT_CYCLES, default 20000, maximum cycles spent waiting for or measuring an echo.
REQ-005 Parameter COOLDOWN_CYCLES, default 200, idle cycles between measurements.
REQ-006 Port clk, input, 1, 1 MHz system clock; one clock domain, all logic on rising edge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port sensor, inout, 1, single-wire ultrasonic sensor signal (trigger out, echo in).
REQ-009 Port distance, output, WIDTH, distance to nearest object in mm, registered.
REQ-010 Port listening, output, 1, high when the driver has released sensor and samples echo.
REQ-011 Port state, output, 3, current FSM state encoding.

Function
REQ-012 FSM states and encodings: IDLE=0, TRIGGER=1, HOLDOFF=2, WAIT_ECHO=3, MEASURE=4, COOLDOWN=5; codes 6-7 unused, treated as IDLE next cycle.
REQ-013 IDLE: one cycle, then TRIGGER.
REQ-014 TRIGGER: sensor driven 1 for exactly TRIG_CYCLES cycles, then HOLDOFF.
REQ-015 HOLDOFF: sensor driven 0 for HOLDOFF_CYCLES cycles, then WAIT_ECHO.
REQ-016 listening SHALL be 1 exactly in WAIT_ECHO and MEASURE; sensor SHALL be Z whenever listening=1 and driven otherwise (1 in TRIGGER, 0 elsewhere).
REQ-017 Echo input passes through a 2-flop synchronizer; all echo decisions use the synchronized value.
REQ-018 WAIT_ECHO: synchronized echo high -> MEASURE with cycle counter cleared to 1; TIMEOUT_CYCLES without echo -> timeout handling.
REQ-019 MEASURE: counter increments each cycle echo stays high; echo low -> distance updated, then COOLDOWN; counter reaching TIMEOUT_CYCLES -> timeout handling.
REQ-020 Distance conversion: mm = (count * 11239 + 32768) >> 16 (343 m/s, round trip, rounded to nearest); SHALL saturate to all ones if result exceeds WIDTH bits; intermediate product width >= bits(TIMEOUT_CYCLES)+14+1.
REQ-021 Timeout handling: distance set to all ones (no object), then COOLDOWN.
REQ-022 distance SHALL hold its last value except on a completed measurement or timeout; update occurs in the cycle leaving MEASURE/WAIT_ECHO.
REQ-023 COOLDOWN: COOLDOWN_CYCLES cycles, sensor driven 0, then IDLE; measurements repeat indefinitely.
REQ-024 Echo already high on entering WAIT_ECHO SHALL be accepted as the echo start.

Reset
REQ-025 reset SHALL force state=IDLE, listening=0, sensor driven 0, distance=0, all counters and synchronizer flops to 0, on the next clk rising edge.
REQ-026 Reset asserted mid-measurement SHALL abort it with no distance update; first trigger begins the cycle after IDLE following reset release.

Structure
REQ-027 Package ping_pkg holds state encodings, scale constant 11239, rounding constant 32768, shift 16.
REQ-028 Single sub-module ping_sync (2-flop synchronizer); FSM, counters and conversion live in ping_driver.

Verification
REQ-029 Reset held 1 cycle then released -> state 0->1, sensor=1 for 5 cycles, then 0 for 2 cycles, then listening=1, state=3.
REQ-030 Echo high 10 cycles after listening -> state 4 during echo, distance=2, then state=5, listening=0.
REQ-031 Echo high 583 cycles -> distance=100; echo 5831 cycles -> distance=1000.
REQ-032 No echo for 20000 cycles in WAIT_ECHO -> distance=16'hFFFF, state=5.
REQ-033 Reset asserted during MEASURE -> next cycle state=0, listening=0, distance=0, sensor driven 0.
REQ-034 Two back-to-back measurements (10 then 583 cycles) -> distance 2 then 100, COOLDOWN of 200 cycles between them.
